// File: rtl/ped_pkg.sv
// Shared types and defaults for the pedestrian gate controller.
// Build option: PED_GATE_SYNC_EN adds a 2-flop input synchronizer in ped_edge_det.
package ped_pkg;

  // Gate FSM states; the encoding is visible on state_out.
  typedef enum logic [1:0] {
    ST_OPEN  = 2'd0,
    ST_LOCK  = 2'd1,
    ST_FULL  = 2'd2,
    ST_CLEAR = 2'd3
  } ped_gate_state_t;

  localparam int unsigned PED_CAPACITY    = 50;
  localparam int unsigned PED_LOCK_CYCLES = 4;
  localparam int unsigned PED_TIMER_BITS  = 8;

  // The lock timer counts down to zero, so the load value is one less
  // than the number of cycles the lock should last.
  function automatic logic [PED_TIMER_BITS-1:0] ped_lock_load(input int unsigned lock_cycles);
    return PED_TIMER_BITS'(lock_cycles - 1);
  endfunction

endpackage

// File: rtl/ped_edge_det.sv
// Turnstile sensor rise detector with optional input synchronizer.
// Build option: PED_GATE_SYNC_EN inserts a 2-flop synchronizer (reset to 1)
// ahead of the delay flop; without it the raw sensor feeds the detector.
module ped_edge_det (
  input  logic i_clk,
  input  logic i_rst,
  input  logic i_sensor,
  output logic o_rise
);

  logic w_sensor_s;
  logic r_sensor_q;

`ifdef PED_GATE_SYNC_EN
  logic r_sync1;
  logic r_sync2;

  // Two-stage synchronizer; resetting to 1 keeps a held sensor from looking like a fresh rise.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_sync1 <= 1'b1;
      r_sync2 <= 1'b1;
    end else begin
      r_sync1 <= i_sensor;
      r_sync2 <= r_sync1;
    end
  end

  assign w_sensor_s = r_sync2;
`else
  assign w_sensor_s = i_sensor;
`endif

  // Delay flop for edge detection; reset to 1 so a sensor high across reset is not counted.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_sensor_q <= 1'b1;
    end else begin
      r_sensor_q <= w_sensor_s;
    end
  end

  assign o_rise = w_sensor_s & ~r_sensor_q;

endmodule

// File: rtl/ped_gate_ctrl.sv
// Pedestrian gate controller: admits passages through a turnstile, drives
// increment/clear strobes to an external pedestrian counter, and closes the
// gate once the counter reports capacity or rollover.
// Build option: PED_GATE_SYNC_EN (input synchronizer inside ped_edge_det).
module ped_gate_ctrl
  import ped_pkg::*;
#(
  parameter int unsigned CNT_BITS    = 6,
  parameter int unsigned CAPACITY    = PED_CAPACITY,
  parameter int unsigned LOCK_CYCLES = PED_LOCK_CYCLES  // legal range 2..255
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                sensor_in,
  input  logic                clear_req,
  input  logic [CNT_BITS-1:0] count_in,
  input  logic                r_flag,
  output logic                cnt_en,
  output logic                cnt_clr,
  output logic                gate_open,
  output logic                full,
  output logic                miss,
  output logic [1:0]          state_out
);

  localparam logic [CNT_BITS-1:0]       CAP_V     = CNT_BITS'(CAPACITY);
  localparam logic [PED_TIMER_BITS-1:0] LOCK_LOAD = ped_lock_load(LOCK_CYCLES);

  ped_gate_state_t           r_state;
  ped_gate_state_t           w_state_nxt;
  logic [PED_TIMER_BITS-1:0] r_timer;
  logic [PED_TIMER_BITS-1:0] w_timer_nxt;
  logic                      r_cnt_en;
  logic                      r_cnt_clr;
  logic                      r_miss;
  logic                      w_cnt_en_nxt;
  logic                      w_cnt_clr_nxt;
  logic                      w_miss_nxt;
  logic                      w_rise;
  logic                      w_at_cap;

  ped_edge_det u_edge_det (
    .i_clk    (clk),
    .i_rst    (rst),
    .i_sensor (sensor_in),
    .o_rise   (w_rise)
  );

  assign w_at_cap = (count_in >= CAP_V) | r_flag;

  // State, lock timer and strobe registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state   <= ST_OPEN;
      r_timer   <= '0;
      r_cnt_en  <= 1'b0;
      r_cnt_clr <= 1'b0;
      r_miss    <= 1'b0;
    end else begin
      r_state   <= w_state_nxt;
      r_timer   <= w_timer_nxt;
      r_cnt_en  <= w_cnt_en_nxt;
      r_cnt_clr <= w_cnt_clr_nxt;
      r_miss    <= w_miss_nxt;
    end
  end

  // Next-state and next-strobe decode; clear_req overrides everything, so
  // a coincident rise is dropped silently. A rise seen while in CLEAR is
  // also dropped: the gate is not yet reopened.
  always_comb begin
    w_state_nxt   = r_state;
    w_timer_nxt   = r_timer;
    w_cnt_en_nxt  = 1'b0;
    w_cnt_clr_nxt = 1'b0;
    w_miss_nxt    = 1'b0;
    if (clear_req) begin
      w_state_nxt   = ST_CLEAR;
      w_timer_nxt   = '0;
      w_cnt_clr_nxt = 1'b1;
    end else begin
      case (r_state)
        ST_OPEN: begin
          if (w_rise) begin
            w_state_nxt  = ST_LOCK;
            w_timer_nxt  = LOCK_LOAD;
            w_cnt_en_nxt = 1'b1;
          end else if (w_at_cap) begin
            w_state_nxt = ST_FULL;
          end
        end
        ST_LOCK: begin
          w_miss_nxt = w_rise;
          if (r_timer == '0) begin
            w_state_nxt = w_at_cap ? ST_FULL : ST_OPEN;
          end else begin
            w_timer_nxt = r_timer - 1'b1;
          end
        end
        ST_FULL: begin
          w_miss_nxt = w_rise;
        end
        ST_CLEAR: begin
          w_state_nxt = ST_OPEN;
        end
        default: begin
          w_state_nxt = ST_OPEN;
        end
      endcase
    end
  end

  assign gate_open = (r_state == ST_OPEN);
  assign full      = (r_state == ST_FULL);
  assign state_out = r_state;
  assign cnt_en    = r_cnt_en;
  assign cnt_clr   = r_cnt_clr;
  assign miss      = r_miss;

endmodule

// File: tb/tb_ped_gate_ctrl.sv
// Self-checking bench for ped_gate_ctrl: directed scenarios plus a random
// run, all compared against a behavioural model of the gate rules.
module tb_ped_gate_ctrl;

  localparam int CNT_BITS    = 6;
  localparam int CAPACITY    = 50;
  localparam int LOCK_CYCLES = 4;
`ifdef PED_GATE_SYNC_EN
  localparam int LAT = 3;
`else
  localparam int LAT = 1;
`endif

  logic                clk = 1'b0;
  logic                rst;
  logic                sensor_in;
  logic                clear_req;
  logic [CNT_BITS-1:0] count_in;
  logic                r_flag;
  logic                cnt_en;
  logic                cnt_clr;
  logic                gate_open;
  logic                full;
  logic                miss;
  logic [1:0]          state_out;

  int    errors = 0;
  int    checks = 0;
  string cur    = "init";

  // Model: 0=open 1=lock 2=full 3=clear; m_left = lock cycles still to serve.
  int m_state;
  int m_left;
  bit m_prev, m_s1, m_s2;
  bit m_en, m_clr, m_miss;

  ped_gate_ctrl #(
    .CNT_BITS    (CNT_BITS),
    .CAPACITY    (CAPACITY),
    .LOCK_CYCLES (LOCK_CYCLES)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .sensor_in (sensor_in),
    .clear_req (clear_req),
    .count_in  (count_in),
    .r_flag    (r_flag),
    .cnt_en    (cnt_en),
    .cnt_clr   (cnt_clr),
    .gate_open (gate_open),
    .full      (full),
    .miss      (miss),
    .state_out (state_out)
  );

  always #5 clk = ~clk;

  task automatic model_step();
    bit s, rise, atcap;
    m_en = 0; m_clr = 0; m_miss = 0;
    if (rst) begin
      m_state = 0; m_left = 0; m_prev = 1; m_s1 = 1; m_s2 = 1;
      return;
    end
`ifdef PED_GATE_SYNC_EN
    s = m_s2; m_s2 = m_s1; m_s1 = sensor_in;
`else
    s = sensor_in;
`endif
    rise   = s && !m_prev;
    m_prev = s;
    atcap  = (int'(count_in) >= CAPACITY) || r_flag;
    if (clear_req) begin
      m_state = 3; m_clr = 1; m_left = 0;
    end else if (m_state == 0) begin
      if (rise) begin m_state = 1; m_left = LOCK_CYCLES; m_en = 1; end
      else if (atcap) m_state = 2;
    end else if (m_state == 1) begin
      m_miss = rise;
      m_left = m_left - 1;
      if (m_left == 0) m_state = atcap ? 2 : 0;
    end else if (m_state == 2) begin
      m_miss = rise;
    end else begin
      m_state = 0;
    end
  endtask

  // One clock: advance model with the inputs seen at the edge, then compare.
  task automatic step();
    @(posedge clk);
    model_step();
    #1;
    checks++; if (state_out !== 2'(m_state)) begin errors++; $display("FAIL %s state_out: got %0d expected %0d", cur, state_out, m_state); end
    checks++; if (gate_open !== (m_state == 0)) begin errors++; $display("FAIL %s gate_open: got %b expected %b", cur, gate_open, (m_state == 0)); end
    checks++; if (full !== (m_state == 2)) begin errors++; $display("FAIL %s full: got %b expected %b", cur, full, (m_state == 2)); end
    checks++; if (cnt_en !== m_en) begin errors++; $display("FAIL %s cnt_en: got %b expected %b", cur, cnt_en, m_en); end
    checks++; if (cnt_clr !== m_clr) begin errors++; $display("FAIL %s cnt_clr: got %b expected %b", cur, cnt_clr, m_clr); end
    checks++; if (miss !== m_miss) begin errors++; $display("FAIL %s miss: got %b expected %b", cur, miss, m_miss); end
  endtask

  task automatic idle(input int n);
    sensor_in = 0; clear_req = 0; count_in = '0; r_flag = 0; rst = 0;
    for (int i = 0; i < n; i++) step();
  endtask

  task automatic test_reset();
    cur = "reset";
    rst = 1; sensor_in = 0; clear_req = 0; count_in = '0; r_flag = 0;
    for (int i = 0; i < 3; i++) step();
    checks++; if (state_out !== 2'd0 || gate_open !== 1'b1 || full !== 1'b0) begin errors++; $display("FAIL reset_state: got st=%0d go=%b full=%b expected st=0 go=1 full=0", state_out, gate_open, full); end
    checks++; if ({cnt_en, cnt_clr, miss} !== 3'b000) begin errors++; $display("FAIL reset_strobes: got %b expected 000", {cnt_en, cnt_clr, miss}); end
    rst = 0;
    idle(LAT + 2);
  endtask

  task automatic test_single_pulse();
    int first_en = -1, n_en = 0, n_lock = 0;
    cur = "single_pulse";
    sensor_in = 1;
    for (int k = 1; k <= LAT + LOCK_CYCLES + 3; k++) begin
      step();
      if (k == 2) sensor_in = 0;
      if (cnt_en === 1'b1) begin n_en++; if (first_en < 0) first_en = k; end
      if (state_out === 2'd1) n_lock++;
    end
    checks++; if (first_en != LAT) begin errors++; $display("FAIL pulse_latency: got %0d expected %0d", first_en, LAT); end
    checks++; if (n_en != 1) begin errors++; $display("FAIL pulse_cnt_en_width: got %0d expected 1", n_en); end
    checks++; if (n_lock != LOCK_CYCLES) begin errors++; $display("FAIL pulse_lock_len: got %0d expected %0d", n_lock, LOCK_CYCLES); end
    checks++; if (state_out !== 2'd0) begin errors++; $display("FAIL pulse_end_state: got %0d expected 0", state_out); end
  endtask

  task automatic test_lock_reject();
    int miss_at = -1, n_miss = 0, n_en = 0, n_lock = 0;
    cur = "lock_reject";
    idle(LAT + 1);
    for (int k = 1; k <= LAT + LOCK_CYCLES + 3; k++) begin
      sensor_in = (k == 1 || k == 3);
      step();
      if (miss === 1'b1) begin n_miss++; if (miss_at < 0) miss_at = k; end
      if (cnt_en === 1'b1) n_en++;
      if (state_out === 2'd1) n_lock++;
    end
    checks++; if (n_miss != 1 || miss_at != LAT + 2) begin errors++; $display("FAIL reject_miss: got n=%0d at=%0d expected n=1 at=%0d", n_miss, miss_at, LAT + 2); end
    checks++; if (n_en != 1) begin errors++; $display("FAIL reject_cnt_en: got %0d expected 1", n_en); end
    checks++; if (n_lock != LOCK_CYCLES) begin errors++; $display("FAIL reject_lock_len: got %0d expected %0d", n_lock, LOCK_CYCLES); end
    sensor_in = 0;
  endtask

  task automatic test_full_and_clear();
    int n_miss = 0, n_en = 0;
    cur = "full_clear";
    idle(LAT + 1);
    for (int k = 1; k <= LAT + LOCK_CYCLES; k++) begin
      sensor_in = (k == 1);
      if (k == LAT + 1) count_in = 6'd50;
      step();
    end
    checks++; if (state_out !== 2'd2 || full !== 1'b1 || gate_open !== 1'b0) begin errors++; $display("FAIL full_entry: got st=%0d full=%b go=%b expected st=2 full=1 go=0", state_out, full, gate_open); end
    for (int k = 1; k <= 6 + LAT; k++) begin
      sensor_in = (k == 1 || k == 3 || k == 5);
      step();
      if (miss === 1'b1) n_miss++;
      if (cnt_en === 1'b1) n_en++;
    end
    checks++; if (n_miss != 3 || n_en != 0) begin errors++; $display("FAIL full_rejects: got miss=%0d en=%0d expected miss=3 en=0", n_miss, n_en); end
    count_in = '0; clear_req = 1;
    step();
    clear_req = 0;
    checks++; if (state_out !== 2'd3 || cnt_clr !== 1'b1) begin errors++; $display("FAIL clear_entry: got st=%0d clr=%b expected st=3 clr=1", state_out, cnt_clr); end
    step();
    checks++; if (state_out !== 2'd0 || cnt_clr !== 1'b0 || gate_open !== 1'b1) begin errors++; $display("FAIL clear_exit: got st=%0d clr=%b go=%b expected st=0 clr=0 go=1", state_out, cnt_clr, gate_open); end
  endtask

  task automatic test_clear_priority();
    int n_en = 0, n_miss = 0;
    cur = "clear_priority";
    idle(LAT + 1);
    sensor_in = 1;
    for (int k = 1; k < LAT; k++) step();
    clear_req = 1;
    step();
    clear_req = 0;
    checks++; if (state_out !== 2'd3 || cnt_en !== 1'b0 || miss !== 1'b0) begin errors++; $display("FAIL prio_entry: got st=%0d en=%b miss=%b expected st=3 en=0 miss=0", state_out, cnt_en, miss); end
    for (int k = 0; k < 6; k++) begin
      step();
      if (cnt_en === 1'b1) n_en++;
      if (miss === 1'b1) n_miss++;
    end
    checks++; if (n_en != 0 || n_miss != 0 || state_out !== 2'd0) begin errors++; $display("FAIL prio_after: got en=%0d miss=%0d st=%0d expected 0 0 0", n_en, n_miss, state_out); end
    sensor_in = 0;
  endtask

  task automatic test_reset_cases();
    int n_str = 0;
    cur = "reset_cases";
    sensor_in = 1; rst = 1;
    for (int k = 0; k < 3; k++) step();
    rst = 0;
    for (int k = 0; k < LAT + 5; k++) begin
      step();
      if (cnt_en === 1'b1) n_str++;
    end
    checks++; if (n_str != 0 || state_out !== 2'd0) begin errors++; $display("FAIL held_sensor: got en=%0d st=%0d expected 0 0", n_str, state_out); end
    idle(LAT + 1);
    sensor_in = 1;
    for (int k = 0; k < LAT + 1; k++) step();
    sensor_in = 0;
    checks++; if (state_out !== 2'd1) begin errors++; $display("FAIL pre_abort_lock: got %0d expected 1", state_out); end
    rst = 1;
    step();
    rst = 0;
    checks++; if (state_out !== 2'd0 || {cnt_en, cnt_clr, miss} !== 3'b000) begin errors++; $display("FAIL abort_state: got st=%0d str=%b expected st=0 str=000", state_out, {cnt_en, cnt_clr, miss}); end
    n_str = 0;
    for (int k = 0; k < LOCK_CYCLES + 2; k++) begin
      step();
      if ((cnt_en | cnt_clr | miss) === 1'b1) n_str++;
    end
    checks++; if (n_str != 0) begin errors++; $display("FAIL abort_trailing: got %0d strobes expected 0", n_str); end
  endtask

  task automatic test_random();
    cur = "random";
    for (int k = 0; k < 3000; k++) begin
      if ($urandom_range(0, 2) == 0) sensor_in = ~sensor_in;
      clear_req = ($urandom_range(0, 24) == 0);
      r_flag    = ($urandom_range(0, 39) == 0);
      rst       = ($urandom_range(0, 199) == 0);
      if ($urandom_range(0, 9) == 0) count_in = CNT_BITS'($urandom_range(48, 63));
      else                           count_in = CNT_BITS'($urandom_range(0, 45));
      step();
    end
    idle(2);
  endtask

  initial begin
    rst = 1; sensor_in = 0; clear_req = 0; count_in = '0; r_flag = 0;
    test_reset();
    test_single_pulse();
    test_lock_reject();
    test_full_and_clear();
    test_clear_priority();
    test_reset_cases();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/ped_gate_ctrl.md
PED_GATE_CTRL -- requirements
Module: ped_gate_ctrl

Interface
REQ-001 The parameter list SHALL be:
- CNT_BITS, 6: counter width.
- CAPACITY, 50: occupancy at which the gate closes.
- LOCK_CYCLES, 4: turnstile lock time after each passage, legal range 2..255.
REQ-002 The ports SHALL be:
- clk  in  1  system clock; all logic on rising edge.
- rst  in  1  synchronous, active-high reset.
- sensor_in  in  1  turnstile sensor, level-high while a pedestrian is passing.
- clear_req  in  1  one-cycle request to empty the occupancy count.
- count_in  in  CNT_BITS  current value from the pedestrian counter.
- r_flag  in  1  rollover flag from the pedestrian counter.
- cnt_en  out  1  one-cycle increment strobe to the counter.
- cnt_clr  out  1  one-cycle clear strobe to the counter.
- gate_open  out  1  gate unlocked.
- full  out  1  capacity reached.
- miss  out  1  one-cycle pulse when a passage is rejected.
- state_out  out  2  current FSM state encoding.

Function
REQ-003 Rise detection SHALL be: rise = sensor_s & ~sensor_q, where sensor_q is sensor_s delayed one clock.
REQ-004 The FSM states SHALL be OPEN=0, LOCK=1, FULL=2, CLEAR=3, with state_out = the state register.
REQ-005 In OPEN, rise SHALL move the FSM to LOCK and assert cnt_en in the next cycle for exactly one cycle.
REQ-006 LOCK SHALL last exactly LOCK_CYCLES cycles, timed by an 8-bit down-counter.
REQ-007 At the end of LOCK, the FSM SHALL go to FULL if count_in >= CAPACITY or r_flag=1; otherwise it SHALL go to OPEN.
REQ-008 A rise in LOCK or FULL SHALL be rejected: no cnt_en, and miss pulses for one cycle.
REQ-009 clear_req=1 in any state SHALL move the FSM to CLEAR next cycle.
REQ-010 clear_req SHALL take priority over a simultaneous rise; that rise is dropped with no cnt_en and no miss.
REQ-011 CLEAR SHALL assert cnt_clr for exactly one cycle and then go to OPEN.
REQ-012 A clear_req received while in CLEAR SHALL re-enter CLEAR.
REQ-013 gate_open SHALL be 1 only in OPEN; full SHALL be 1 only in FULL. Both SHALL be decoded from registered state, with no combinational path from inputs.
REQ-014 cnt_en, cnt_clr and miss SHALL be registered and mutually exclusive in any cycle.
REQ-015 An OPEN-state check SHALL also apply: if count_in >= CAPACITY or r_flag=1 while in OPEN with no rise, the FSM SHALL go to FULL next cycle.

Reset
REQ-016 While rst=1 the block SHALL hold: state=OPEN, gate_open=1, full=0, cnt_en=0, cnt_clr=0, miss=0, timer=0, sensor_q=1.
REQ-017 Holding sensor_q=1 SHALL prevent a sensor held high across reset from counting.
REQ-018 Reset asserted mid-LOCK or mid-CLEAR SHALL abort the operation with no trailing strobe.

Configuration
REQ-019 With PED_GATE_SYNC_EN defined, sensor_s SHALL be sensor_in passed through a 2-flop synchronizer, adding 2 cycles to rise-to-cnt_en latency. Synchronizer flops SHALL reset to 1.
REQ-020 Without PED_GATE_SYNC_EN, sensor_s SHALL be sensor_in directly.

Structure
REQ-021 A shared package ped_pkg SHALL hold the state enum ped_gate_state_t and the defaults PED_CAPACITY=50 and PED_LOCK_CYCLES=4.
REQ-022 The design SHALL use one sub-module, ped_edge_det (optional synchronizer, delay flop and rise output), instantiated once.
REQ-023 The pedestrian counter SHALL be instantiated outside this block.

Verification
REQ-024 Reset then a single sensor pulse (macro off) -> cnt_en high exactly 1 cycle, on the cycle after the rise is sampled; state_out goes 0->1->0 after 4 LOCK cycles.
REQ-025 Second rise 2 cycles into LOCK -> miss=1 for 1 cycle, no cnt_en, LOCK length unchanged.
REQ-026 Drive count_in=50 during LOCK -> FULL at LOCK end with full=1, gate_open=0; further rises produce miss only.
REQ-027 In FULL, clear_req for 1 cycle -> state CLEAR, cnt_clr=1 for 1 cycle, then OPEN with gate_open=1.
REQ-028 clear_req coincident with a rise in OPEN -> CLEAR, no cnt_en, no miss.
REQ-029 sensor_in held high through reset release -> no cnt_en; rst during LOCK -> OPEN next cycle, no strobes.
REQ-030 With PED_GATE_SYNC_EN defined -> rise-to-cnt_en latency is 3 cycles.
